// File: rtl/mux_ctrl_defs.sv
// Shared definitions for the round-robin 4:1 mux arbiter.
package mux_ctrl_defs;

  localparam int unsigned NREQ = 4;
  localparam int unsigned SELW = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic [NREQ-1:0] onehot_sel(input logic [SELW-1:0] sel);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4.sv
// Single-bit 4:1 mux used by the data path, one instance per data bit.
module mux4 (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y
);

  always_comb begin
    y = d[0];
    case (sel)
      2'd0:    y = d[0];
      2'd1:    y = d[1];
      2'd2:    y = d[2];
      default: y = d[3];
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set request at or after ptr, wrapping mod 4.
import mux_ctrl_defs::*;

module rr_pick4 (
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic            any,
  output logic [SELW-1:0] idx
);

  logic [SELW-1:0] cand;
  logic            found;

  always_comb begin
    any   = |req;
    idx   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + SELW'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a registered 4:1 mux select with optional hold timeout.
import mux_ctrl_defs::*;

module mux4_rr_arbiter #(
  parameter int unsigned DW       = 1,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CW       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] i,
  output logic [NREQ-1:0]    grant,
  output logic [SELW-1:0]    s,
  output logic [DW-1:0]      y,
  output logic               valid,
  output logic               preempt
);

  localparam bit            HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CW-1:0] HOLD_LAST = HOLD_EN ? CW'(MAX_HOLD - 1) : '0;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [SELW-1:0] s_q, s_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            preempt_q, preempt_d;

  logic            pick_any;
  logic [SELW-1:0] pick_idx;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      s_q       <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      s_q       <= s_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  // Release wins over timeout when the owner drops req on the limit cycle.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    s_d       = s_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_BUSY;
          grant_d = onehot_sel(pick_idx);
          s_d     = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (!req[s_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = s_q + SELW'(1);
        end else if (HOLD_EN && (cnt_q == HOLD_LAST)) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          ptr_d     = s_q + SELW'(1);
          preempt_d = 1'b1;
        end else if (HOLD_EN) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant   = grant_q;
  assign s       = s_q;
  assign preempt = preempt_q;
  assign valid   = (state_q == ST_BUSY) && req[s_q];

  for (genvar b = 0; b < DW; b++) begin : g_bit
    logic [NREQ-1:0] lane_bits;
    for (genvar k = 0; k < NREQ; k++) begin : g_lane
      assign lane_bits[k] = i[k*DW + b];
    end
    mux4 u_mux (
      .d   (lane_bits),
      .sel (s_q),
      .y   (y[b])
    );
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench: instance A has no hold limit, instance B preempts after 3 cycles.
module tb_mux4_rr_arbiter;

  localparam int unsigned DW       = 4;
  localparam int unsigned MH_B     = 3;
  // A waiter may also sit through the bubble before the three other owners' turns.
  localparam int          WAIT_MAX = 3 * (MH_B + 1) + 1;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] s;
    logic       valid;
    logic [3:0] y;
    logic       preempt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req_a, req_b;
  logic [15:0] i_a, i_b;
  logic [3:0]  grant_a, grant_b;
  logic [1:0]  s_a, s_b;
  logic [3:0]  y_a, y_b;
  logic        valid_a, valid_b, preempt_a, preempt_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   sb_en = 1'b0;
  bit   rnd_en = 1'b0;
  int   w [4];
  logic [3:0] prev_req = '0;

  mux4_rr_arbiter #(.DW(DW), .MAX_HOLD(0), .CW(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .i(i_a), .grant(grant_a), .s(s_a),
    .y(y_a), .valid(valid_a), .preempt(preempt_a)
  );

  mux4_rr_arbiter #(.DW(DW), .MAX_HOLD(MH_B), .CW(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .i(i_b), .grant(grant_b), .s(s_b),
    .y(y_b), .valid(valid_b), .preempt(preempt_b)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] g, input logic [1:0] sel, input logic v,
                              input logic [3:0] yy, input logic p);
    exp_t r;
    r.grant = g; r.s = sel; r.valid = v; r.y = yy; r.preempt = p;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input bit is_b, input exp_t act);
    exp_t e;
    n_cmp++;
    if ((is_b && q_b.size() == 0) || (!is_b && q_a.size() == 0)) begin
      n_bad++;
      $display("FAIL sb_%s: unexpected output g=%b s=%0d v=%b y=%h p=%b at %0t",
               is_b ? "b" : "a", act.grant, act.s, act.valid, act.y, act.preempt, $time);
    end else begin
      e = is_b ? q_b.pop_front() : q_a.pop_front();
      if (act !== e) begin
        n_bad++;
        $display("FAIL sb_%s: got g=%b s=%0d v=%b y=%h p=%b want g=%b s=%0d v=%b y=%h p=%b at %0t",
                 is_b ? "b" : "a", act.grant, act.s, act.valid, act.y, act.preempt,
                 e.grant, e.s, e.valid, e.y, e.preempt, $time);
      end
    end
  endtask

  task automatic monitor_loop();
    logic [3:0] wmax;
    forever begin
      @(negedge clk);
      if (sb_en) begin
        if (grant_a != 4'b0 || preempt_a) sb_pop(1'b0, mk(grant_a, s_a, valid_a, y_a, preempt_a));
        if (grant_b != 4'b0 || preempt_b) sb_pop(1'b1, mk(grant_b, s_b, valid_b, y_b, preempt_b));
      end
      if (rnd_en) begin
        n_cmp++;
        if (!$onehot0(grant_b)) begin
          n_bad++;
          $display("FAIL rnd_onehot0: grant=%b at %0t", grant_b, $time);
        end
        n_cmp++;
        if (valid_b && !grant_b[s_b]) begin
          n_bad++;
          $display("FAIL rnd_valid_grant: grant=%b s=%0d at %0t", grant_b, s_b, $time);
        end
        wmax = '0;
        for (int k = 0; k < 4; k++) begin
          if (req_b[k] && !grant_b[k]) w[k] = prev_req[k] ? w[k] + 1 : 0;
          else w[k] = 0;
          if (w[k] > int'(wmax)) wmax = 4'(w[k]);
        end
        prev_req = req_b;
        n_cmp++;
        if (int'(wmax) > WAIT_MAX) begin
          n_bad++;
          $display("FAIL rnd_starve: wait=%0d limit=%0d at %0t", wmax, WAIT_MAX, $time);
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] ra, input logic [3:0] rb);
    req_a = ra;
    req_b = rb;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
    #3;
    chk("rst_grant_a", 32'(grant_a), 32'h0);
    chk("rst_s_a", 32'(s_a), 32'h0);
    chk("rst_valid_a", 32'(valid_a), 32'h0);
    chk("rst_y_a", 32'(y_a), 32'hA);
    chk("rst_grant_b", 32'(grant_b), 32'h0);
    chk("rst_preempt_b", 32'(preempt_b), 32'h0);
    chk("rst_y_b", 32'(y_b), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drained(input string nm);
    chk(nm, 32'(q_a.size() + q_b.size()), 32'h0);
    q_a.delete();
    q_b.delete();
  endtask

  logic [3:0] t2_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] t2_s [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] t2_y [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};

  initial begin
    logic [3:0] rb;
    req_a = '0;
    req_b = '0;
    i_a   = 16'hDCBA;
    i_b   = 16'h4321;
    for (int k = 0; k < 4; k++) w[k] = 0;
    fork
      monitor_loop();
    join_none
    #3;

    // Single requester on lane 2, then release.
    apply_reset();
    sb_en = 1'b1;
    q_a.push_back(mk(4'b0100, 2'd2, 1'b1, 4'hC, 1'b0));
    q_a.push_back(mk(4'b0100, 2'd2, 1'b0, 4'hC, 1'b0));
    step(4'b0100, 4'b0);
    step(4'b0100, 4'b0);
    step(4'b0000, 4'b0);
    chk("t1_release", 32'(grant_a), 32'h0);
    step(4'b0000, 4'b0);
    drained("t1_drain");

    // All four requesting, owners release in turn.
    apply_reset();
    for (int n = 0; n < 5; n++) begin
      q_a.push_back(mk(t2_g[n], t2_s[n], 1'b1, t2_y[n], 1'b0));
      q_a.push_back(mk(t2_g[n], t2_s[n], 1'b0, t2_y[n], 1'b0));
      step(4'b1111, 4'b0);
      step(4'b1111, 4'b0);
      step(4'b1111 & ~t2_g[n], 4'b0);
    end
    step(4'b0000, 4'b0);
    drained("t2_drain");

    // Lone requester 1 on the timed instance: 3 grant cycles then preempt bubble.
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) q_b.push_back(mk(4'b0010, 2'd1, 1'b1, 4'h2, 1'b0));
      q_b.push_back(mk(4'b0000, 2'd1, 1'b0, 4'h2, 1'b1));
    end
    for (int c = 0; c < 12; c++) step(4'b0, 4'b0010);
    step(4'b0, 4'b0000);
    step(4'b0, 4'b0000);
    chk("t3_preempt_low", 32'(preempt_b), 32'h0);
    drained("t3_drain");

    // Owner drops req on the limit cycle: release, no preempt, ptr moves to 1.
    apply_reset();
    q_b.push_back(mk(4'b0001, 2'd0, 1'b1, 4'h1, 1'b0));
    q_b.push_back(mk(4'b0001, 2'd0, 1'b1, 4'h1, 1'b0));
    q_b.push_back(mk(4'b0001, 2'd0, 1'b0, 4'h1, 1'b0));
    q_b.push_back(mk(4'b0010, 2'd1, 1'b1, 4'h2, 1'b0));
    q_b.push_back(mk(4'b0010, 2'd1, 1'b0, 4'h2, 1'b0));
    step(4'b0, 4'b0001);
    step(4'b0, 4'b0001);
    step(4'b0, 4'b0001);
    step(4'b0, 4'b0000);
    step(4'b0, 4'b1111);
    step(4'b0, 4'b1111);
    step(4'b0, 4'b1101);
    step(4'b0, 4'b0000);
    drained("t4_drain");

    // Async reset while requester 3 owns the path.
    apply_reset();
    q_a.push_back(mk(4'b1000, 2'd3, 1'b1, 4'hD, 1'b0));
    step(4'b1000, 4'b0);
    step(4'b1000, 4'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_grant", 32'(grant_a), 32'h0);
    chk("t5_s", 32'(s_a), 32'h0);
    chk("t5_valid", 32'(valid_a), 32'h0);
    chk("t5_y", 32'(y_a), 32'hA);
    req_a = 4'b1111;
    q_a.push_back(mk(4'b0001, 2'd0, 1'b1, 4'hA, 1'b0));
    q_a.push_back(mk(4'b0001, 2'd0, 1'b0, 4'hA, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(4'b1111, 4'b0);
    step(4'b1110, 4'b0);
    step(4'b0000, 4'b0);
    drained("t5_drain");

    // Random sticky requests on the timed instance with per-cycle invariants.
    apply_reset();
    sb_en  = 1'b0;
    rnd_en = 1'b1;
    rb     = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (rb[k] && grant_b[k]) begin
          if ($urandom_range(3) == 0) rb[k] = 1'b0;
        end else if (!rb[k]) begin
          if ($urandom_range(1) == 1) rb[k] = 1'b1;
        end
      end
      step(4'b0, rb);
    end
    rnd_en = 1'b0;
    step(4'b0, 4'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
